// File: rtl/fwbq_pkg.sv
// Shared types for the FP write-back queue: queue entry layout and source age order.
// Entry data is sized for the widest supported FP register; narrower builds use the low bits.
package fwbq_pkg;

  localparam int unsigned FLEN_MAX = 64;
  localparam int unsigned NSRC     = 3;

  // Same-cycle arrivals are older the lower their source index.
  typedef enum logic [1:0] {
    SRC_FMA  = 2'd0,
    SRC_LOAD = 2'd1,
    SRC_DIV  = 2'd2
  } fwbq_src_e;

  typedef struct packed {
    logic [4:0]          rd;
    logic [FLEN_MAX-1:0] data;
  } fwbq_entry_t;

endpackage

// File: rtl/fwb_fifo.sv
// Circular entry store for fwb_queue: up to NSRC in-order pushes and one pop per cycle.
// Exposes per-slot occupancy and destination registers for outstanding-write tracking.
module fwb_fifo
  import fwbq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  fwbq_entry_t                push_e [NSRC],
  input  logic [1:0]                 push_n,
  input  logic                       pop,
  output fwbq_entry_t                head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [DEPTH-1:0]           occ,
  output logic [4:0]                 ent_rd [DEPTH]
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fwbq_entry_t   mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  // Pushes land after the current tail; the caller guarantees they fit after the pop.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (i < 32'(push_n)) begin
        mem[wptr + PW'(i)] <= push_e[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PW'(push_n);
      rptr  <= rptr + PW'(pop);
      count <= count - CW'(pop) + CW'(push_n);
    end
  end

  always_comb begin
    head = mem[rptr];
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occ[i]    = 32'(PW'(PW'(i) - rptr)) < 32'(count);
      ent_rd[i] = mem[i].rd;
    end
  end

endmodule

// File: rtl/fwb_queue.sv
// FP write-back queue merging FMA, load and divide results onto one register-file write port.
// Optional FWBQ_PENDING_EN builds the per-register outstanding-write flags.
module fwb_queue
  import fwbq_pkg::*;
#(
  parameter int unsigned FLEN  = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       FmaValid,
  input  logic [4:0]                 FmaRd,
  input  logic [FLEN-1:0]            FmaRes,
  input  logic                       LoadValid,
  input  logic [4:0]                 LoadRd,
  input  logic [FLEN-1:0]            LoadData,
  input  logic                       DivValid,
  input  logic [4:0]                 DivRd,
  input  logic [FLEN-1:0]            DivRes,
  output logic                       DivReady,
  output logic                       Stall,
  output logic                       WE,
  output logic [4:0]                 WAdr,
  output logic [FLEN-1:0]            WD,
  output logic [31:0]                Pending,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Overflow
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic          src_v  [NSRC];
  fwbq_entry_t   src_e  [NSRC];
  fwbq_entry_t   arr    [NSRC];
  fwbq_entry_t   arr_sh [NSRC];
  fwbq_entry_t   push_e [NSRC];
  logic [1:0]    n_arr;
  logic [1:0]    push_n;
  logic          pop;
  logic          out_v;
  fwbq_entry_t   out_e;
  fwbq_entry_t   head;
  logic [CW-1:0] cnt;
  logic [DEPTH-1:0] occ;
  logic [4:0]    ent_rd [DEPTH];
  int unsigned   want;
  int unsigned   space;
  int unsigned   cnt_nxt;
  logic          ovf_now;

  fwb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_e (push_e),
    .push_n (push_n),
    .pop    (pop),
    .head   (head),
    .count  (cnt),
    .occ    (occ),
    .ent_rd (ent_rd)
  );

  assign Count    = cnt;
  assign pop      = (cnt != '0);
  assign DivReady = (32'(cnt) - 32'(pop) + 32'(FmaValid) + 32'(LoadValid)) < DEPTH;

  always_comb begin
    src_v[SRC_FMA]  = FmaValid;
    src_v[SRC_LOAD] = LoadValid;
    src_v[SRC_DIV]  = DivValid && DivReady;
    src_e[SRC_FMA]  = '{rd: FmaRd,  data: FLEN_MAX'(FmaRes)};
    src_e[SRC_LOAD] = '{rd: LoadRd, data: FLEN_MAX'(LoadData)};
    src_e[SRC_DIV]  = '{rd: DivRd,  data: FLEN_MAX'(DivRes)};

    // Compact accepted arrivals into age order.
    n_arr = '0;
    for (int unsigned i = 0; i < NSRC; i++) arr[i] = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (src_v[i]) begin
        arr[n_arr] = src_e[i];
        n_arr      = n_arr + 2'd1;
      end
    end
    arr_sh[NSRC-1] = '0;
    for (int unsigned i = 0; i < NSRC - 1; i++) arr_sh[i] = arr[i+1];

    // A non-empty queue always owns the output register; otherwise the oldest arrival bypasses.
    out_v = pop || (n_arr != '0);
    out_e = pop ? head : arr[0];
    for (int unsigned i = 0; i < NSRC; i++) push_e[i] = pop ? arr[i] : arr_sh[i];

    want    = pop ? 32'(n_arr) : ((n_arr != '0) ? 32'(n_arr) - 1 : 0);
    space   = DEPTH - 32'(cnt) + 32'(pop);
    ovf_now = want > space;
    push_n  = ovf_now ? 2'(space) : 2'(want);
    cnt_nxt = 32'(cnt) - 32'(pop) + 32'(push_n);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      WE       <= 1'b0;
      WAdr     <= '0;
      WD       <= '0;
      Stall    <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      WE       <= out_v;
      WAdr     <= out_e.rd;
      WD       <= out_e.data[FLEN-1:0];
      Stall    <= cnt_nxt >= DEPTH - 1;
      Overflow <= Overflow | ovf_now;
    end
  end

`ifdef FWBQ_PENDING_EN
  always_comb begin
    Pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (occ[i]) Pending[ent_rd[i]] = 1'b1;
    end
    if (WE) Pending[WAdr] = 1'b1;
  end
`else
  logic pend_unused;
  assign Pending = '0;
  always_comb begin
    pend_unused = ^occ;
    for (int unsigned i = 0; i < DEPTH; i++) pend_unused = pend_unused ^ (^ent_rd[i]);
  end
`endif

endmodule

// File: tb/tb_fwb_queue.sv
// Randomized self-checking bench for fwb_queue against a queue-based reference model.
// Expected Pending follows FWBQ_PENDING_EN the same way the design build does.
module tb_fwb_queue;

  localparam int unsigned FLEN  = 64;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            FmaValid, LoadValid, DivValid;
  logic [4:0]      FmaRd, LoadRd, DivRd;
  logic [FLEN-1:0] FmaRes, LoadData, DivRes;
  logic            DivReady, Stall, WE, Overflow;
  logic [4:0]      WAdr;
  logic [FLEN-1:0] WD;
  logic [31:0]     Pending;
  logic [$clog2(DEPTH+1)-1:0] Count;

  fwb_queue #(.FLEN(FLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .FmaValid(FmaValid), .FmaRd(FmaRd), .FmaRes(FmaRes),
    .LoadValid(LoadValid), .LoadRd(LoadRd), .LoadData(LoadData),
    .DivValid(DivValid), .DivRd(DivRd), .DivRes(DivRes),
    .DivReady(DivReady), .Stall(Stall), .WE(WE), .WAdr(WAdr), .WD(WD),
    .Pending(Pending), .Count(Count), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      rd;
    logic [FLEN-1:0] d;
  } ent_t;

  ent_t            q[$];
  logic            m_we;
  logic [4:0]      m_rd;
  logic [FLEN-1:0] m_wd;
  logic            m_ovf;
  int unsigned     checks = 0;
  int unsigned     failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_pending();
    logic [31:0] p = '0;
`ifdef FWBQ_PENDING_EN
    foreach (q[i]) p[q[i].rd] = 1'b1;
    if (m_we) p[m_rd] = 1'b1;
`endif
    return p;
  endfunction

  function automatic logic exp_ready(input logic fv, input logic lv);
    int n = q.size();
    return (n - ((n > 0) ? 1 : 0) + int'(fv) + int'(lv)) < int'(DEPTH);
  endfunction

  task automatic check_outputs();
    check("we", 64'(WE), 64'(m_we));
    if (m_we) begin
      check("wadr", 64'(WAdr), 64'(m_rd));
      check("wd", WD, m_wd);
    end
    check("count", 64'(Count), 64'(q.size()));
    check("stall", 64'(Stall), 64'(q.size() >= DEPTH - 1));
    check("overflow", 64'(Overflow), 64'(m_ovf));
    check("pending", 64'(Pending), 64'(exp_pending()));
  endtask

  // One clock of stimulus: drive at negedge, check handshake, advance model, check registered outputs.
  task automatic step(input logic fv, input logic [4:0] fr, input logic [63:0] fd,
                      input logic lv, input logic [4:0] lr, input logic [63:0] ld,
                      input logic dv, input logic [4:0] dr, input logic [63:0] dd);
    ent_t all[$];
    logic rdy;
    @(negedge clk);
    FmaValid = fv; FmaRd = fr; FmaRes = fd;
    LoadValid = lv; LoadRd = lr; LoadData = ld;
    DivValid = dv; DivRd = dr; DivRes = dd;
    #1;
    rdy = exp_ready(fv, lv);
    check("divready", 64'(DivReady), 64'(rdy));
    @(posedge clk);
    all = q;
    if (fv) all.push_back('{fr, fd});
    if (lv) all.push_back('{lr, ld});
    if (dv && rdy) all.push_back('{dr, dd});
    m_we = 1'b0;
    if (all.size() > 0) begin
      m_we = 1'b1;
      m_rd = all[0].rd;
      m_wd = all[0].d;
      void'(all.pop_front());
    end
    while (all.size() > DEPTH) begin
      void'(all.pop_back());
      m_ovf = 1'b1;
    end
    q = all;
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    FmaValid = 0; LoadValid = 0; DivValid = 0;
    reset = 1'b1;
    #1;
    q.delete(); m_we = 0; m_ovf = 0;
    check("rst_we", 64'(WE), 64'd0);
    check("rst_count", 64'(Count), 64'd0);
    check("rst_pending", 64'(Pending), 64'd0);
    check("rst_stall", 64'(Stall), 64'd0);
    check("rst_overflow", 64'(Overflow), 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    FmaValid = 0; LoadValid = 0; DivValid = 0;
    FmaRd = 0; LoadRd = 0; DivRd = 0;
    FmaRes = 0; LoadData = 0; DivRes = 0;
    reset = 1'b1;
    q.delete(); m_we = 0; m_ovf = 0; m_rd = 0; m_wd = 0;
    #12;
    check("init_we", 64'(WE), 64'd0);
    check("init_count", 64'(Count), 64'd0);
    do_reset();

    // Single FMA into an empty queue reaches the write port one cycle later.
    step(1, 5'd3, 64'h3FF0000000000000, 0, 0, 0, 0, 0, 0);
    check("bypass_wadr", 64'(WAdr), 64'd3);
    check("bypass_wd", WD, 64'h3FF0000000000000);
    idle();

    // Three simultaneous sources retire in source order.
    step(1, 5'd1, 64'h11, 1, 5'd2, 64'h22, 1, 5'd4, 64'h44);
    check("order0", 64'(WAdr), 64'd1);
    idle();
    check("order1", 64'(WAdr), 64'd2);
    idle();
    check("order2", 64'(WAdr), 64'd4);
    idle(); idle();

    // Two writes to the same register.
    step(1, 5'd5, 64'h55, 1, 5'd5, 64'h56, 0, 0, 0);
    idle(); idle(); idle();

    // Fill to three, then show Div held, then overflow on a full queue.
    step(1, 5'd6, 64'h60, 1, 5'd7, 64'h70, 1, 5'd8, 64'h80);
    step(1, 5'd9, 64'h90, 1, 5'd10, 64'hA0, 0, 0, 0);
    check("stall_at3", 64'(Stall), 64'd1);
    step(1, 5'd11, 64'hB0, 1, 5'd12, 64'hC0, 1, 5'd13, 64'hD0);
    step(1, 5'd14, 64'hE0, 1, 5'd15, 64'hF0, 1, 5'd13, 64'hD0);
    check("overflow_set", 64'(Overflow), 64'd1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 1, 5'd13, 64'hD0);
    for (int i = 0; i < 3; i++) idle();

    // Reset with entries in flight.
    do_reset();
    step(1, 5'd1, 64'h1, 1, 5'd2, 64'h2, 1, 5'd3, 64'h3);
    step(1, 5'd4, 64'h4, 1, 5'd5, 64'h5, 0, 0, 0);
    do_reset();
    idle(); idle();

    // Randomized traffic with a small register set to force same-Rd collisions.
    for (int n = 0; n < 2000; n++) begin
      logic fv, lv, dv;
      fv = ($urandom_range(99) < 50);
      lv = ($urandom_range(99) < 40);
      dv = ($urandom_range(99) < 50);
      if (Stall && $urandom_range(99) < 90) begin
        fv = 0; lv = 0;
      end
      if (n == 1000) do_reset();
      step(fv, 5'($urandom_range(7)), {$urandom, $urandom},
           lv, 5'($urandom_range(7)), {$urandom, $urandom},
           dv, 5'($urandom_range(7)), {$urandom, $urandom});
    end
    for (int i = 0; i < 6; i++) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwb_queue.md
FWB_QUEUE -- requirements
Module: fwb_queue

Interface
REQ-001 SHALL have parameter FLEN, default 64, FP register width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; power of two and at least 4.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports FmaValid/FmaRd/FmaRes, input, 1/5/FLEN, FMA/convert result; cannot be back-pressured.
REQ-006 SHALL have ports LoadValid/LoadRd/LoadData, input, 1/5/FLEN, FP load result; cannot be back-pressured.
REQ-007 SHALL have ports DivValid/DivRd/DivRes, input, 1/5/FLEN, divide/sqrt result; accepted only on DivValid&DivReady.
REQ-008 SHALL have port DivReady, output, 1, divider handshake ready.
REQ-009 SHALL have port Stall, output, 1, registered; upstream holds FMA/load issue.
REQ-010 SHALL have ports WE/WAdr/WD, output, 1/5/FLEN, registered write port driving FP register file we4/a4/wd4.
REQ-011 SHALL have port Pending, output, 32, per-register outstanding-write flags.
REQ-012 SHALL have port Count, output, $clog2(DEPTH+1), occupied entries.
REQ-013 SHALL have port Overflow, output, 1, sticky protocol-error flag.

Function
REQ-014 SHALL define age order per cycle: queued entries (oldest first), then Fma, Load, Div arrivals.
REQ-015 SHALL load the output register each cycle with the oldest of {queue head, accepted arrivals}; WE=0 when none.
REQ-016 SHALL enqueue all other accepted arrivals in age order; up to 3 pushes plus 1 pop per cycle.
REQ-017 SHALL give 1-cycle latency from arrival to WE when queue is empty.
REQ-018 SHALL assert DivReady combinationally iff Count - pop + FmaValid + LoadValid < DEPTH, pop = (Count>0).
REQ-019 SHALL assert Stall on next cycle iff next Count >= DEPTH-1.
REQ-020 SHALL set Overflow and drop the youngest arrival(s) when FMA/load arrivals exceed free space; no other state corrupted.
REQ-021 SHALL hold Pending[r]=1 while any queue entry or valid output register has Rd r; clear only when last such write leaves.
REQ-022 SHALL treat register 0 as an ordinary register.
REQ-023 SHALL never reorder two writes to the same Rd.
REQ-024 SHALL wrap read/write pointers modulo DEPTH; Count distinguishes full from empty.

Reset
REQ-025 SHALL on reset immediately clear WE, Count, Stall, Overflow, and Pending, and empty the queue; WAdr/WD are don't-care.
REQ-026 SHALL discard in-flight entries on reset mid-operation; no WE pulse follows reset release without new arrivals.

Configuration
REQ-027 SHALL compile Pending logic only when FWBQ_PENDING_EN is defined; otherwise Pending SHALL be tied to 32'b0 and no comparators are built.

Structure
REQ-028 SHALL place fwbq_entry_t {rd[4:0], data[FLEN-1:0]} and the source-order constants in shared package fwbq_pkg.
REQ-029 SHALL implement storage and pointers as sub-module fwb_fifo (multi-push, single-pop); arbitration, handshake, and flags stay in fwb_queue.

Verification
REQ-030 Empty queue, FmaValid, Rd=3, Res=0x3FF0000000000000 -> next cycle WE=1, WAdr=3, WD equal; Count=0.
REQ-031 Same cycle Fma Rd=1, Load Rd=2, Div Rd=4 valid and ready -> WE on 3 consecutive cycles with Rd 1, 2, 4.
REQ-032 Count=3, DEPTH=4 -> Stall=1 and DivReady=0 when Fma and Load are both valid; Div held until Count<=2.
REQ-033 Two writes to Rd=5 queued -> Pending[5]=1 until the second WE retires, then 0; FWBQ_PENDING_EN undefined -> Pending=0 throughout.
REQ-034 Queue full and Fma+Load arrive -> Overflow=1 sticky; existing entries drain intact.
REQ-035 Reset asserted with Count=3 -> WE, Count, and Pending are 0 immediately, with no WE after release.
